// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath.
// master = sequencer side, slave = datapath/memory side.
interface multicycle_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [5:0]       Op;
   logic [5:0]       Func;
   logic             Z;
   logic             MemReady;
   logic             Iord;
   logic             Mrd;
   logic             Wmem;
   logic             Wir;
   logic             Wpc;
   logic [1:0]       Pcsrc;
   logic             Regrt;
   logic             Se;
   logic             Aluqb;
   logic [3:0]       Aluc;
   logic             shift;
   logic             Reg2reg;
   logic             Wreg;
   logic             j;
   logic [2:0]       State;
   logic             Halt;
   logic [CNT_W-1:0] Icount;

   modport master (
      input  Op, Func, Z, MemReady,
      output Iord, Mrd, Wmem, Wir, Wpc, Pcsrc,
      output Regrt, Se, Aluqb, Aluc, shift,
      output Reg2reg, Wreg, j, State, Halt, Icount
   );

   modport slave (
      output Op, Func, Z, MemReady,
      input  Iord, Mrd, Wmem, Wir, Wpc, Pcsrc,
      input  Regrt, Se, Aluqb, Aluc, shift,
      input  Reg2reg, Wreg, j, State, Halt, Icount
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the MIPS-subset datapath.
// Steps each instruction through IF/ID/EX/MEM/WB over one shared memory port.
module multicycle_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic              Clk,
   input  logic              Rst,
   multicycle_ctrl_if.master bus
);
   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic             halt_q;
   logic [CNT_W-1:0] cnt_q;
   logic             retire;

   logic       legal;
   logic       is_j;
   logic       is_jal;
   logic       is_jr;
   logic       is_beq;
   logic       is_bne;
   logic       is_lw;
   logic       is_sw;
   logic [3:0] d_aluc;
   logic       d_aluqb;
   logic       d_se;
   logic       d_shift;
   logic       d_regrt;

   always_comb begin
      legal   = 1'b1;
      is_j    = 1'b0;
      is_jal  = 1'b0;
      is_jr   = 1'b0;
      is_beq  = 1'b0;
      is_bne  = 1'b0;
      is_lw   = 1'b0;
      is_sw   = 1'b0;
      d_aluc  = 4'b0000;
      d_aluqb = 1'b0;
      d_se    = 1'b0;
      d_shift = 1'b0;
      d_regrt = 1'b1;
      unique case (bus.Op)
         6'h00: begin
            d_aluqb = 1'b1;
            d_regrt = 1'b0;
            unique case (bus.Func)
               6'h20: d_aluc = 4'b0000;
               6'h22: d_aluc = 4'b0001;
               6'h24: d_aluc = 4'b0010;
               6'h25: d_aluc = 4'b0011;
               6'h26: d_aluc = 4'b0100;
               6'h00: begin d_aluc = 4'b0101; d_shift = 1'b1; end
               6'h02: begin d_aluc = 4'b0111; d_shift = 1'b1; end
               6'h03: begin d_aluc = 4'b1111; d_shift = 1'b1; end
               6'h08: is_jr = 1'b1;
               default: legal = 1'b0;
            endcase
         end
         6'h08: d_se = 1'b1;
         6'h0c: d_aluc = 4'b0010;
         6'h0d: d_aluc = 4'b0011;
         6'h0e: d_aluc = 4'b0100;
         6'h0f: d_aluc = 4'b0110;
         6'h23: begin is_lw = 1'b1; d_se = 1'b1; end
         6'h2b: begin is_sw = 1'b1; d_se = 1'b1; end
         // branches compare rs against rt, so B comes from the register file
         6'h04: begin
            is_beq = 1'b1; d_aluc = 4'b0001;
            d_se = 1'b1; d_aluqb = 1'b1;
         end
         6'h05: begin
            is_bne = 1'b1; d_aluc = 4'b0001;
            d_se = 1'b1; d_aluqb = 1'b1;
         end
         6'h02: is_j = 1'b1;
         6'h03: is_jal = 1'b1;
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      bus.Iord    = 1'b0;
      bus.Mrd     = 1'b0;
      bus.Wmem    = 1'b0;
      bus.Wir     = 1'b0;
      bus.Wpc     = 1'b0;
      bus.Pcsrc   = 2'b00;
      bus.Regrt   = 1'b0;
      bus.Se      = 1'b0;
      bus.Aluqb   = 1'b0;
      bus.Aluc    = 4'b0000;
      bus.shift   = 1'b0;
      bus.Reg2reg = 1'b0;
      bus.Wreg    = 1'b0;
      bus.j       = 1'b0;
      // decoded ALU controls stay up from EX through WB
      if (state_q == S_EX || state_q == S_MEM || state_q == S_WB) begin
         bus.Aluc  = d_aluc;
         bus.Aluqb = d_aluqb;
         bus.Se    = d_se;
         bus.shift = d_shift;
         bus.Regrt = d_regrt;
      end
      unique case (state_q)
         S_IF: begin
            bus.Mrd = 1'b1;
            if (bus.MemReady) begin
               bus.Wir = 1'b1;
               bus.Wpc = 1'b1;
               state_d = S_ID;
            end
         end
         S_ID: begin
            if (!legal) begin
               state_d = S_HALT;
            end else if (is_j || is_jal) begin
               bus.Wpc   = 1'b1;
               bus.Pcsrc = 2'b11;
               bus.Wreg  = is_jal;
               bus.j     = is_jal;
               state_d   = S_IF;
            end else if (is_jr) begin
               bus.Wpc   = 1'b1;
               bus.Pcsrc = 2'b10;
               bus.j     = 1'b1;
               state_d   = S_IF;
            end else begin
               state_d = S_EX;
            end
         end
         S_EX: begin
            if (is_beq || is_bne) begin
               if (is_beq ? bus.Z : !bus.Z) begin
                  bus.Wpc   = 1'b1;
                  bus.Pcsrc = 2'b01;
               end
               state_d = S_IF;
            end else if (is_lw || is_sw) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            bus.Iord = 1'b1;
            bus.Mrd  = is_lw;
            bus.Wmem = !is_lw;
            if (bus.MemReady) state_d = is_lw ? S_WB : S_IF;
         end
         S_WB: begin
            bus.Wreg    = 1'b1;
            bus.Reg2reg = !is_lw;
            state_d     = S_IF;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_IF;
      endcase
      if (Rst) begin
         bus.Wpc  = 1'b0;
         bus.Wir  = 1'b0;
         bus.Wreg = 1'b0;
         bus.Wmem = 1'b0;
         bus.Mrd  = 1'b0;
      end
   end

   assign retire = (state_d == S_IF) && (state_q != S_IF);

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= S_IF;
         halt_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_d == S_HALT) halt_q <= 1'b1;
         if (retire) cnt_q <= cnt_q + 1'b1;
      end
   end

   assign bus.State  = state_q;
   assign bus.Halt   = halt_q;
   assign bus.Icount = cnt_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized scoreboard bench for multicycle_ctrl.
// Expected per-cycle controls come from an instruction-level model.
module tb_multicycle_ctrl;
   localparam int CW = 6;

   localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_OR = 3, K_XOR = 4;
   localparam int K_SLL = 5, K_SRL = 6, K_SRA = 7, K_JR = 8;
   localparam int K_ADDI = 9, K_ANDI = 10, K_ORI = 11, K_XORI = 12;
   localparam int K_LW = 13, K_SW = 14, K_BEQ = 15, K_BNE = 16;
   localparam int K_LUI = 17, K_J = 18, K_JAL = 19;
   localparam int K_BAD = 20, K_BADR = 21;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   multicycle_ctrl_if #(.CNT_W(CW)) bus ();
   multicycle_ctrl #(.CNT_W(CW)) dut (
      .Clk (clk),
      .Rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [2:0] st;
      logic       iord, mrd, wmem, wir, wpc;
      logic [1:0] pcsrc;
      logic       regrt, se, aluqb;
      logic [3:0] aluc;
      logic       shift, reg2reg, wreg, j, halt;
   } obs_t;

   typedef struct {
      obs_t          exp;
      obs_t          msk;
      logic [CW-1:0] icnt;
      logic [63:0]   tag;
   } chk_t;

   chk_t          exp_q[$];
   int            vectors = 0;
   int            miscompares = 0;
   int            cyc = 0;
   logic [CW-1:0] retired = '0;

   function automatic logic [5:0] k_op(int k);
      case (k)
         K_ADDI: return 6'h08;
         K_ANDI: return 6'h0c;
         K_ORI:  return 6'h0d;
         K_XORI: return 6'h0e;
         K_LW:   return 6'h23;
         K_SW:   return 6'h2b;
         K_BEQ:  return 6'h04;
         K_BNE:  return 6'h05;
         K_LUI:  return 6'h0f;
         K_J:    return 6'h02;
         K_JAL:  return 6'h03;
         K_BAD:  return 6'h3f;
         default: return 6'h00;
      endcase
   endfunction

   function automatic logic [5:0] k_fn(int k);
      case (k)
         K_ADD:  return 6'h20;
         K_SUB:  return 6'h22;
         K_AND:  return 6'h24;
         K_OR:   return 6'h25;
         K_XOR:  return 6'h26;
         K_SLL:  return 6'h00;
         K_SRL:  return 6'h02;
         K_SRA:  return 6'h03;
         K_JR:   return 6'h08;
         K_BADR: return 6'h21;
         default: return 6'($urandom);
      endcase
   endfunction

   function automatic logic [3:0] k_aluc(int k);
      case (k)
         K_SUB, K_BEQ, K_BNE: return 4'b0001;
         K_AND, K_ANDI:       return 4'b0010;
         K_OR, K_ORI:         return 4'b0011;
         K_XOR, K_XORI:       return 4'b0100;
         K_SLL:               return 4'b0101;
         K_SRL:               return 4'b0111;
         K_SRA:               return 4'b1111;
         K_LUI:               return 4'b0110;
         default:             return 4'b0000;
      endcase
   endfunction

   function automatic obs_t k_dec(int k);
      obs_t d = '0;
      d.aluc  = k_aluc(k);
      d.shift = (k >= K_SLL && k <= K_SRA);
      d.aluqb = (k <= K_SRA) || k == K_BEQ || k == K_BNE;
      d.se    = k inside {K_ADDI, K_LW, K_SW, K_BEQ, K_BNE};
      d.regrt = k inside {K_ADDI, K_ANDI, K_ORI, K_XORI,
                          K_LW, K_SW, K_LUI};
      return d;
   endfunction

   function automatic obs_t k_msk(int k);
      obs_t m = '1;
      if (k == K_BEQ || k == K_BNE) begin
         m.aluqb = 1'b0;
         m.regrt = 1'b0;
      end
      if (k == K_SW) m.regrt = 1'b0;
      if (k <= K_SRA || k == K_LUI) m.se = 1'b0;
      return m;
   endfunction

   // during reset only the state, Halt and the enables are pinned
   function automatic obs_t rst_msk();
      obs_t m = '0;
      m.st   = '1;
      m.mrd  = 1'b1;
      m.wmem = 1'b1;
      m.wir  = 1'b1;
      m.wpc  = 1'b1;
      m.wreg = 1'b1;
      m.halt = 1'b1;
      return m;
   endfunction

   task automatic step(input logic r, input logic mr, input logic z,
                       input logic [5:0] op, input logic [5:0] fn,
                       input obs_t e, input obs_t m,
                       input logic [63:0] tag);
      chk_t c;
      @(posedge clk);
      #1;
      rst          = r;
      bus.MemReady = mr;
      bus.Z        = z;
      bus.Op       = op;
      bus.Func     = fn;
      c.exp  = e;
      c.msk  = m;
      c.icnt = retired;
      c.tag  = tag;
      exp_q.push_back(c);
   endtask

   task automatic do_instr(input int k, input int ifw, input int memw,
                           input logic z, input logic abort);
      obs_t e, d, m;
      logic [5:0] op, fn;
      logic br, tk;
      op = k_op(k);
      fn = k_fn(k);
      d  = k_dec(k);
      m  = k_msk(k);
      for (int i = 0; i < ifw; i++) begin
         e = '0; e.mrd = 1'b1;
         step(0, 0, 1'($urandom), 6'($urandom), 6'($urandom),
              e, '1, "IF-wait");
      end
      e = '0; e.mrd = 1'b1; e.wir = 1'b1; e.wpc = 1'b1;
      step(0, 1, 1'($urandom), 6'($urandom), 6'($urandom),
           e, '1, "IF");
      e = '0; e.st = 3'd1;
      if (k == K_J || k == K_JAL) begin
         e.wpc = 1'b1; e.pcsrc = 2'b11;
      end
      if (k == K_JAL) begin e.wreg = 1'b1; e.j = 1'b1; end
      if (k == K_JR) begin
         e.wpc = 1'b1; e.pcsrc = 2'b10; e.j = 1'b1;
      end
      step(0, 1'($urandom), 1'($urandom), op, fn, e, '1, "ID");
      if (k inside {K_J, K_JAL, K_JR}) begin
         retired = retired + 1'b1;
         return;
      end
      if (k == K_BAD || k == K_BADR) begin
         for (int i = 0; i < 20; i++) begin
            e = '0; e.st = 3'd5; e.halt = 1'b1;
            step(0, 1'($urandom), 1'($urandom), op, fn, e, '1, "HALT");
         end
         e = '0; e.st = 3'd5; e.halt = 1'b1;
         step(1, 1'($urandom), 1'($urandom), op, fn,
              e, rst_msk(), "RST-HALT");
         retired = '0;
         return;
      end
      br = (k == K_BEQ || k == K_BNE);
      tk = (k == K_BEQ) ? z : !z;
      e = d; e.st = 3'd2;
      if (br && tk) begin e.wpc = 1'b1; e.pcsrc = 2'b01; end
      step(0, 1'($urandom), z, op, fn, e, m, "EX");
      if (br) begin
         retired = retired + 1'b1;
         return;
      end
      if (k == K_LW || k == K_SW) begin
         e = d; e.st = 3'd3; e.iord = 1'b1;
         if (k == K_LW) e.mrd = 1'b1;
         else e.wmem = 1'b1;
         for (int i = 0; i < memw; i++)
            step(0, 0, 1'($urandom), op, fn, e, m, "MEM-wait");
         if (abort) begin
            e = '0; e.st = 3'd3;
            step(1, 0, 1'($urandom), op, fn, e, rst_msk(), "RST-MEM");
            retired = '0;
            return;
         end
         step(0, 1, 1'($urandom), op, fn, e, m, "MEM");
         if (k == K_SW) begin
            retired = retired + 1'b1;
            return;
         end
      end
      e = d; e.st = 3'd4; e.wreg = 1'b1; e.reg2reg = (k != K_LW);
      step(0, 1'($urandom), 1'($urandom), op, fn, e, m, "WB");
      retired = retired + 1'b1;
   endtask

   task automatic rand_run(input int n);
      for (int i = 0; i < n; i++)
         do_instr($urandom_range(0, 19), $urandom_range(0, 2),
                  $urandom_range(0, 3), 1'($urandom), 1'b0);
   endtask

   always @(negedge clk) begin : monitor
      obs_t a;
      chk_t c;
      if (exp_q.size() > 0) begin
         c = exp_q.pop_front();
         a.st      = bus.State;
         a.iord    = bus.Iord;
         a.mrd     = bus.Mrd;
         a.wmem    = bus.Wmem;
         a.wir     = bus.Wir;
         a.wpc     = bus.Wpc;
         a.pcsrc   = bus.Pcsrc;
         a.regrt   = bus.Regrt;
         a.se      = bus.Se;
         a.aluqb   = bus.Aluqb;
         a.aluc    = bus.Aluc;
         a.shift   = bus.shift;
         a.reg2reg = bus.Reg2reg;
         a.wreg    = bus.Wreg;
         a.j       = bus.j;
         a.halt    = bus.Halt;
         vectors++;
         if ((((a ^ c.exp) & c.msk) !== '0) || (bus.Icount !== c.icnt)) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h icount=%0d want=%h icount=%0d mask=%h",
                     c.tag, cyc, a, bus.Icount, c.exp, c.icnt, c.msk);
         end
      end
      cyc++;
   end

   initial begin : stim
      obs_t e;
      bus.Op = '0;
      bus.Func = '0;
      bus.Z = 1'b0;
      bus.MemReady = 1'b0;
      for (int i = 0; i < 2; i++) begin
         e = '0;
         step(1, 1'($urandom), 1'($urandom), 6'($urandom), 6'($urandom),
              e, '1, "RESET");
      end
      do_instr(K_ADD, 0, 0, 1'b0, 1'b0);
      do_instr(K_LW, 2, 3, 1'b0, 1'b0);
      do_instr(K_BEQ, 0, 0, 1'b1, 1'b0);
      do_instr(K_BEQ, 0, 0, 1'b0, 1'b0);
      do_instr(K_JAL, 0, 0, 1'b0, 1'b0);
      do_instr(K_JR, 0, 0, 1'b0, 1'b0);
      do_instr(K_BNE, 1, 0, 1'b0, 1'b0);
      do_instr(K_SW, 0, 1, 1'b0, 1'b1);
      do_instr(K_SW, 1, 2, 1'b0, 1'b0);
      rand_run(60);
      do_instr(K_BADR, 0, 0, 1'b0, 1'b0);
      rand_run(100);
      do_instr(K_BAD, 0, 0, 1'b0, 1'b0);
      do_instr(K_ADD, 0, 0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain left=%0d want=0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule
